// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: serializes W-bit words into an external sequence detector,
// counts the detector's match flags per word and keeps a saturating total.
// Optional build macro SEQ_DET_CTRL_MSB_FIRST_EN selects MSB-first serial
// order; without it words are presented LSB first.
module seq_det_ctrl #(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  output logic                     det_rst,
  output logic                     det_bit,
  output logic                     det_en,
  input  logic                     det_out,
  output logic                     res_valid,
  output logic [$clog2(W+1)-1:0]   res_count,
  output logic [15:0]              tot_count
);

  localparam int CW = $clog2(W+1);
  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {CLR, IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    sreg;
  logic [BW-1:0]   bit_cnt;
  logic [CW-1:0]   match_cnt;
  logic [CW-1:0]   res_q;
  logic [CW-1:0]   final_cnt;
  logic            en_q;
  logic [15:0]     tot_q;
  logic [16:0]     tot_sum;
  logic [15:0]     tot_next;
  logic            ser_bit;
  logic            accept;

`ifdef SEQ_DET_CTRL_MSB_FIRST_EN
  assign ser_bit = sreg[W-1];
`else
  assign ser_bit = sreg[0];
`endif

  assign accept    = in_valid && (state == IDLE);
  assign tot_count = tot_q;

  // Next-state and per-state control outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    det_en    = 1'b0;
    det_bit   = 1'b0;
    res_valid = 1'b0;
    det_rst   = reset;
    case (state)
      CLR: begin
        det_rst   = 1'b1;
        state_nxt = IDLE;
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        det_en  = 1'b1;
        det_bit = ser_bit;
        if (bit_cnt == BW'(W-1)) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = CLR;
    endcase
  end

  // Final word count folds in the detector response to the last bit, which
  // only arrives during DONE; tot_count saturates instead of wrapping
  always_comb begin
    final_cnt = match_cnt + CW'(det_out);
    tot_sum   = {1'b0, tot_q} + 17'(final_cnt);
    tot_next  = tot_sum[16] ? '1 : tot_sum[15:0];
    res_count = (state == DONE) ? final_cnt : res_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= CLR;
    else       state <= state_nxt;
  end

  // Shift register, bit/match counters and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      en_q      <= 1'b0;
      res_q     <= '0;
      tot_q     <= '0;
    end else begin
      en_q <= det_en;
      if (accept) begin
        sreg      <= in_data;
        bit_cnt   <= '0;
        match_cnt <= '0;
      end else begin
        if (state == SHIFT) begin
`ifdef SEQ_DET_CTRL_MSB_FIRST_EN
          sreg <= {sreg[W-2:0], 1'b0};
`else
          sreg <= {1'b0, sreg[W-1:1]};
`endif
          bit_cnt <= bit_cnt + BW'(1);
        end
        if (en_q && det_out) match_cnt <= match_cnt + CW'(1);
      end
      if (state == DONE) begin
        res_q <= final_cnt;
        tot_q <= tot_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed, table-driven bench for seq_det_ctrl (W=8) plus hand-written
// reset, back-to-back, abort and saturation sequences.
module tb_seq_det_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        det_rst;
  logic        det_bit;
  logic        det_en;
  logic        det_out;
  logic        res_valid;
  logic [3:0]  res_count;
  logic [15:0] tot_count;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  seq_det_ctrl #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .det_rst   (det_rst),
    .det_bit   (det_bit),
    .det_en    (det_en),
    .det_out   (det_out),
    .res_valid (res_valid),
    .res_count (res_count),
    .tot_count (tot_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [8:0]  dpat;     // det_out in cycles t+1 .. t+9 after acceptance
    logic [7:0]  seq_lsb;  // expected det_bit[j] for SHIFT cycle j, LSB first
    logic [7:0]  seq_msb;  // same, MSB first
    int unsigned res;
    int unsigned tot;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pick_seq(input logic [7:0] lsb, input logic [7:0] msb);
`ifdef SEQ_DET_CTRL_MSB_FIRST_EN
    return msb;
`else
    return lsb;
`endif
  endfunction

  task automatic wait_ready();
    int unsigned n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Offers one word, drives det_out from dpat and checks the whole transaction
  task automatic run_word(input logic [7:0] data, input logic [8:0] dpat,
                          input logic [7:0] eseq, input int unsigned eres,
                          input int unsigned etot);
    logic [7:0]  seq = '0;
    int unsigned en_hi = 0;
    int unsigned rdy_low = 0;
    int unsigned early = 0;
    wait_ready();
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    for (int j = 0; j <= 8; j++) begin
      det_out = dpat[j];
      #1;
      if (!in_ready) rdy_low++;
      if (j < 8) begin
        seq[j] = det_bit;
        if (det_en) en_hi++;
        if (res_valid) early++;
      end else begin
        check("res_valid_at_t+9", 32'(res_valid), 32'd1);
        check("res_count", 32'(res_count), eres);
        check("det_bit_idle_zero", 32'({det_en, det_bit}), 32'd0);
      end
      @(posedge clk); #1;
    end
    det_out = 1'b0;
    check("det_bit_sequence", 32'(seq), 32'(eseq));
    check("det_en_cycles", en_hi, 32'd8);
    check("early_res_valid", early, 32'd0);
    check("in_ready_low_cycles", rdy_low, 32'd9);
    check("res_valid_pulse_end", 32'(res_valid), 32'd0);
    check("res_count_hold", 32'(res_count), eres);
    check("tot_count", 32'(tot_count), etot);
  endtask

  initial begin
    logic [1:0]  rst_seq [4];
    int unsigned rv_seen;

    vecs[0] = '{8'hB2, 9'h000,         8'hB2, 8'h4D, 0, 0};
    vecs[1] = '{8'hB2, 9'h1FF,         8'hB2, 8'h4D, 8, 8};
    vecs[2] = '{8'h5A, 9'b1_0101_0101, 8'h5A, 8'h5A, 4, 12};
    vecs[3] = '{8'hFF, 9'h001,         8'hFF, 8'hFF, 0, 12};
    vecs[4] = '{8'h00, 9'h100,         8'h00, 8'h00, 1, 13};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    det_out  = 1'b0;

    // Reset held for two edges, then released: det_rst 1,1,1,0 / in_ready 0,0,0,1
    #1;
    rst_seq[0] = {det_rst, in_ready};
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 2) reset = 1'b0;
      #1;
      rst_seq[c] = {det_rst, in_ready};
    end
    check("reset_cycle1", 32'(rst_seq[0]), 32'b10);
    check("reset_cycle2", 32'(rst_seq[1]), 32'b10);
    check("clr_cycle3",   32'(rst_seq[2]), 32'b10);
    check("idle_cycle4",  32'(rst_seq[3]), 32'b01);
    check("reset_outputs", 32'({det_en, det_bit, res_valid, res_count, tot_count}), 32'd0);

    // Table-driven words
    for (int i = 0; i < 5; i++)
      run_word(vecs[i].data, vecs[i].dpat, pick_seq(vecs[i].seq_lsb, vecs[i].seq_msb),
               vecs[i].res, vecs[i].tot);

    // Fresh reset, then three back-to-back words with det_out high throughout
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_clears_tot", 32'(tot_count), 32'd0);
    check("reset_clears_res", 32'(res_count), 32'd0);
    for (int k = 1; k <= 3; k++)
      run_word(8'hB2, 9'h1FF, pick_seq(8'hB2, 8'h4D), 8, 8 * k);

    // Abort: reset asserted during the 4th SHIFT cycle
    wait_ready();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    det_out  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int s = 1; s < 4; s++) begin
      @(posedge clk); #1;
    end
    check("abort_in_shift", 32'(det_en), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_state_clr", 32'({det_rst, in_ready, det_en, det_bit}), 32'b1000);
    check("abort_tot_zero", 32'(tot_count), 32'd0);
    rv_seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (res_valid) rv_seen++;
      @(posedge clk); #1;
    end
    det_out = 1'b0;
    check("abort_no_res_valid", rv_seen, 32'd0);
    run_word(8'hB2, 9'h1FF, pick_seq(8'hB2, 8'h4D), 8, 8);

    // Saturation: preload the total just below the ceiling
    force dut.tot_q = 16'hFFFC;
    #1;
    release dut.tot_q;
    #1;
    check("preload_tot", 32'(tot_count), 32'h0000FFFC);
    run_word(8'hB2, 9'h1FF, pick_seq(8'hB2, 8'h4D), 8, 32'h0000FFFF);
    run_word(8'h5A, 9'h1FF, pick_seq(8'h5A, 8'h5A), 8, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
